pong_scoreboard: RTL and testbench
==================================

Name: pong_scoreboard

Overview:
- Parametrised two-player score keeper for the pong game.
- Detects goal events from the ball/collision logic on the rising edge and increments the scoring player's counter.
- Enforces win-by-margin and saturation rules.
- Sequences serve pauses and game-over, and gates the ball engine via ball_enable.

Parameters:
- SCORE_W, 4: width of each score counter; max score is 2^SCORE_W-1.
- WIN_SCORE, 11: minimum score needed to win; must be ≤ 2^SCORE_W-1.
- WIN_BY, 2: required lead to win; 1 means first to WIN_SCORE wins.
- PAUSE_CYCLES, 50000000: clocks of ball freeze after each point before re-serve; must be ≥ 1.
- PAUSE_W, 26: width of the pause counter; must hold PAUSE_CYCLES-1.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous active-high reset.
- start, input, 1: level; begins a new game from IDLE or OVER.
- goal_left, input, 1: level flag; ball passed player one's side, so player two scores.
- goal_right, input, 1: level flag; ball passed player two's side, so player one scores.
- p_one_score, output, SCORE_W: player one score, registered.
- p_two_score, output, SCORE_W: player two score, registered.
- ball_enable, output, 1: high only while in PLAY.
- serve_dir, output, 1: 0 serves toward player one, 1 toward player two; the loser of the last point receives.
- point_pulse, output, 1: one-cycle pulse on each accepted point.
- game_over, output, 1: high in OVER.
- winner, output, 2: 00 none, 01 player one, 10 player two.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - Both scores 0; ball_enable 0; serve_dir 0; point_pulse 0; game_over 0; winner 00.
  - Edge-detect history registers 0; pause counter 0.
  - Reset overrides all other inputs in the same cycle.
- Edge detection: goal_x_rise = goal_x & ~goal_x_q, with goal_x_q registered every cycle in every state. A held-high goal flag scores once only.
- States:
  - IDLE: scores held. start → clear both scores, serve_dir=0, go to PAUSE.
  - PLAY: ball_enable=1. Exactly one rise accepted → point (see below). Both rises in the same cycle → no point, remain in PLAY, no pulse.
  - PAUSE: counter counts 0..PAUSE_CYCLES-1, then goes to PLAY on the next clock. Goal edges are ignored. The counter is cleared on entry.
  - OVER: game_over=1 and winner held. start → clear scores and winner, go to PAUSE.
- Point handling, registered in the cycle after the edge:
  - The scorer's counter increments by 1, saturating at 2^SCORE_W-1.
  - point_pulse=1 for exactly that cycle.
  - serve_dir is set toward the player who conceded.
- Win check, evaluated on the post-increment score in the same cycle. The scorer wins if either:
  - (new ≥ WIN_SCORE and new − other ≥ WIN_BY), or
  - new == 2^SCORE_W-1 (saturation tiebreak; prevents endless deuce).
- On a win: go to OVER and set winner. Otherwise go to PAUSE.
- ball_enable drops the same cycle point_pulse asserts.
- start is ignored in PLAY and PAUSE.
- Arithmetic: margin is computed in SCORE_W+1 bits, signed-safe (compare new > other first).
- Latency: goal edge to score update and point_pulse is 1 clock after the edge is registered, i.e. 2 clocks from the input rising.

Decomposition:
- Shared package pong_pkg:
  - State enum (IDLE, PAUSE, PLAY, OVER).
  - Winner encodings (WIN_NONE, WIN_P1, WIN_P2).
  - Serve direction constants (SERVE_P1, SERVE_P2).
- One natural sub-module: pong_edge_detect.
  - Registered rising-edge detector, parametrised width, synchronous active-high reset.
  - Instantiated once with width 2 for both goal inputs.

Test Plan (bench params SCORE_W=3, WIN_SCORE=3, WIN_BY=2, PAUSE_CYCLES=4):
- Reset then start → PAUSE for 4 clocks then ball_enable=1; scores 0/0; winner 00.
- In PLAY, goal_right held high 10 clocks → p_one_score=1 exactly once; one point_pulse; serve_dir=1; ball_enable low for 4 clocks, then high.
- goal_left and goal_right rise in the same cycle → no score change, no pulse, ball_enable stays 1.
- Deuce: reach 3/3, P1 scores → 4/3, no win; P1 scores → 5/3 → OVER, winner=01, game_over=1, ball_enable=0.
- Saturation: alternate points to 6/6, P2 scores → 6/7 (max) → OVER, winner=10; further goal edges change nothing.
- Assert reset mid-PAUSE at score 2/1 → next clock IDLE, scores 0/0; start while in PLAY has no effect.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and encodings for the pong score keeper.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PAUSE = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  localparam logic SERVE_P1 = 1'b0;
  localparam logic SERVE_P2 = 1'b1;

endpackage

// File: rtl/pong_edge_detect.sv
// Registered rising-edge detector; each output pulses one clock after its input goes 0->1.
module pong_edge_detect #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_sig,
  output logic [WIDTH-1:0] o_rise
);

  logic [WIDTH-1:0] r_sig_q;
  logic [WIDTH-1:0] r_rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sig_q <= '0;
      r_rise  <= '0;
    end else begin
      r_sig_q <= i_sig;
      r_rise  <= i_sig & ~r_sig_q;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/pong_scoreboard.sv
// Two-player pong score keeper: goal edge scoring, win-by-margin with saturation
// tiebreak, serve pauses and game-over sequencing.
module pong_scoreboard
  import pong_pkg::*;
#(
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 11,
  parameter int WIN_BY       = 2,
  parameter int PAUSE_CYCLES = 50000000,
  parameter int PAUSE_W      = 26
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               goal_left,
  input  logic               goal_right,
  output logic [SCORE_W-1:0] p_one_score,
  output logic [SCORE_W-1:0] p_two_score,
  output logic               ball_enable,
  output logic               serve_dir,
  output logic               point_pulse,
  output logic               game_over,
  output logic [1:0]         winner
);

  localparam logic [SCORE_W-1:0] SCORE_MAX   = '1;
  localparam logic [SCORE_W:0]   WIN_SCORE_X = (SCORE_W+1)'(WIN_SCORE);
  localparam logic [SCORE_W:0]   WIN_BY_X    = (SCORE_W+1)'(WIN_BY);
  localparam logic [PAUSE_W-1:0] PAUSE_LAST  = PAUSE_W'(PAUSE_CYCLES - 1);

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == SCORE_MAX) ? s : s + SCORE_W'(1);
  endfunction

  // Margin only taken when the scorer leads, so the subtraction never wraps.
  function automatic logic is_win(input logic [SCORE_W-1:0] nw,
                                  input logic [SCORE_W-1:0] other);
    logic [SCORE_W:0] n_x;
    logic [SCORE_W:0] o_x;
    logic [SCORE_W:0] margin;
    n_x    = {1'b0, nw};
    o_x    = {1'b0, other};
    margin = (n_x > o_x) ? (n_x - o_x) : '0;
    return ((n_x >= WIN_SCORE_X) && (margin >= WIN_BY_X)) || (nw == SCORE_MAX);
  endfunction

  state_t               r_state;
  state_t               w_state_nxt;
  logic [PAUSE_W-1:0]   r_pause_cnt;
  logic [SCORE_W-1:0]   r_p1;
  logic [SCORE_W-1:0]   r_p2;
  logic                 r_serve;
  logic                 r_point;
  logic [1:0]           r_winner;
  logic [1:0]           w_rise;
  logic                 w_p1_pt;
  logic                 w_p2_pt;
  logic [SCORE_W-1:0]   w_p1_new;
  logic [SCORE_W-1:0]   w_p2_new;
  logic                 w_p1_win;
  logic                 w_p2_win;
  logic                 w_start_game;
  logic                 w_ball_enable;
  logic                 w_game_over;

  pong_edge_detect #(.WIDTH(2)) u_goal_edge (
    .clk    (clk),
    .reset  (reset),
    .i_sig  ({goal_right, goal_left}),
    .o_rise (w_rise)
  );

  // A simultaneous rise on both sides is ambiguous and scores nothing.
  assign w_p1_pt      = (r_state == PLAY) && (w_rise == 2'b10);
  assign w_p2_pt      = (r_state == PLAY) && (w_rise == 2'b01);
  assign w_p1_new     = sat_inc(r_p1);
  assign w_p2_new     = sat_inc(r_p2);
  assign w_p1_win     = w_p1_pt && is_win(w_p1_new, r_p2);
  assign w_p2_win     = w_p2_pt && is_win(w_p2_new, r_p1);
  assign w_start_game = start && ((r_state == IDLE) || (r_state == OVER));

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (start) w_state_nxt = PAUSE;
      PAUSE: if (r_pause_cnt == PAUSE_LAST) w_state_nxt = PLAY;
      PLAY: begin
        if (w_p1_win || w_p2_win)     w_state_nxt = OVER;
        else if (w_p1_pt || w_p2_pt)  w_state_nxt = PAUSE;
      end
      OVER:  if (start) w_state_nxt = PAUSE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_ball_enable = (r_state == PLAY);
    w_game_over   = (r_state == OVER);
  end

  // Held at zero outside PAUSE so every entry starts a fresh count.
  always_ff @(posedge clk) begin
    if (reset)                          r_pause_cnt <= '0;
    else if (r_state != PAUSE)          r_pause_cnt <= '0;
    else if (r_pause_cnt != PAUSE_LAST) r_pause_cnt <= r_pause_cnt + PAUSE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_p1     <= '0;
      r_p2     <= '0;
      r_serve  <= SERVE_P1;
      r_point  <= 1'b0;
      r_winner <= WIN_NONE;
    end else begin
      r_point <= w_p1_pt | w_p2_pt;
      if (w_start_game) begin
        r_p1     <= '0;
        r_p2     <= '0;
        r_winner <= WIN_NONE;
        if (r_state == IDLE) r_serve <= SERVE_P1;
      end
      if (w_p1_pt) begin
        r_p1    <= w_p1_new;
        r_serve <= SERVE_P2;
        if (w_p1_win) r_winner <= WIN_P1;
      end
      if (w_p2_pt) begin
        r_p2    <= w_p2_new;
        r_serve <= SERVE_P1;
        if (w_p2_win) r_winner <= WIN_P2;
      end
    end
  end

  assign p_one_score = r_p1;
  assign p_two_score = r_p2;
  assign ball_enable = w_ball_enable;
  assign serve_dir   = r_serve;
  assign point_pulse = r_point;
  assign game_over   = w_game_over;
  assign winner      = r_winner;

endmodule

// File: tb/tb_pong_scoreboard.sv
// Scoreboard bench for pong_scoreboard with a small, fast game configuration.
module tb_pong_scoreboard;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       goal_left = 1'b0;
  logic       goal_right = 1'b0;
  logic [2:0] p_one_score;
  logic [2:0] p_two_score;
  logic       ball_enable;
  logic       serve_dir;
  logic       point_pulse;
  logic       game_over;
  logic [1:0] winner;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [2:0] p1;
    logic [2:0] p2;
    logic       serve;
    logic [1:0] win;
  } exp_t;

  exp_t exp_q[$];

  int         m_p1 = 0;
  int         m_p2 = 0;
  logic       m_serve = 1'b0;
  logic [1:0] m_win = 2'b00;

  pong_scoreboard #(
    .SCORE_W(3), .WIN_SCORE(3), .WIN_BY(2), .PAUSE_CYCLES(4), .PAUSE_W(3)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .goal_left(goal_left), .goal_right(goal_right),
    .p_one_score(p_one_score), .p_two_score(p_two_score),
    .ball_enable(ball_enable), .serve_dir(serve_dir),
    .point_pulse(point_pulse), .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  // Every point pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (point_pulse === 1'b1) begin
      exp_t e;
      exp_t got;
      checks++;
      got = {p_one_score, p_two_score, serve_dir, winner};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_point got p1=%0d p2=%0d serve=%0b win=%b", p_one_score, p_two_score, serve_dir, winner);
      end else begin
        e = exp_q.pop_front();
        if (got !== e)
          begin
            errors++;
            $display("FAIL point_result got p1=%0d p2=%0d serve=%0b win=%b expected p1=%0d p2=%0d serve=%0b win=%b",
                     p_one_score, p_two_score, serve_dir, winner, e.p1, e.p2, e.serve, e.win);
          end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_win(int a, int b);
    return ((a >= 3) && (a - b >= 2)) || (a == 7);
  endfunction

  task automatic wait_play();
    int n = 0;
    while (ball_enable !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (ball_enable !== 1'b1) begin
      errors++;
      $display("FAIL wait_play ball_enable=%b expected 1 within 20 clocks", ball_enable);
    end
  endtask

  task automatic start_game();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic model_new_game(input bit from_idle);
    m_p1  = 0;
    m_p2  = 0;
    m_win = 2'b00;
    if (from_idle) m_serve = 1'b0;
  endtask

  // Ends on the clock where the point registers; the goal flag is dropped there.
  task automatic score_point(input bit p1s);
    exp_t e;
    wait_play();
    if (p1s) begin
      if (m_p1 < 7) m_p1++;
      m_serve = 1'b1;
      if (model_win(m_p1, m_p2)) m_win = 2'b01;
    end else begin
      if (m_p2 < 7) m_p2++;
      m_serve = 1'b0;
      if (model_win(m_p2, m_p1)) m_win = 2'b10;
    end
    e.p1 = 3'(m_p1);
    e.p2 = 3'(m_p2);
    e.serve = m_serve;
    e.win = m_win;
    exp_q.push_back(e);
    if (p1s) goal_right = 1'b1;
    else     goal_left  = 1'b1;
    tick();
    tick();
    goal_right = 1'b0;
    goal_left  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({p_one_score, p_two_score, ball_enable, serve_dir, point_pulse, game_over, winner} !== 12'b0) begin
      errors++;
      $display("FAIL reset_state got p1=%0d p2=%0d be=%b sd=%b pp=%b go=%b win=%b expected all zero",
               p_one_score, p_two_score, ball_enable, serve_dir, point_pulse, game_over, winner);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (ball_enable !== 1'b0 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold be=%b go=%b expected 0 0", ball_enable, game_over);
    end
  endtask

  task automatic test_start_pause();
    int lows = 0;
    start_game();
    model_new_game(1'b1);
    for (int i = 0; i < 4; i++) begin
      if (ball_enable === 1'b0) lows++;
      tick();
    end
    checks++;
    if (lows != 4) begin
      errors++;
      $display("FAIL start_pause low_cycles=%0d expected 4", lows);
    end
    checks++;
    if (ball_enable !== 1'b1) begin
      errors++;
      $display("FAIL start_play ball_enable=%b expected 1", ball_enable);
    end
    checks++;
    if (p_one_score !== 3'd0 || p_two_score !== 3'd0 || winner !== 2'b00) begin
      errors++;
      $display("FAIL start_scores got %0d/%0d win=%b expected 0/0 00", p_one_score, p_two_score, winner);
    end
  endtask

  task automatic test_held_goal();
    int pulses = 0;
    int lows = 0;
    exp_t e;
    m_p1 = 1;
    m_serve = 1'b1;
    e.p1 = 3'd1; e.p2 = 3'd0; e.serve = 1'b1; e.win = 2'b00;
    exp_q.push_back(e);
    goal_right = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (point_pulse === 1'b1) pulses++;
      if (ball_enable === 1'b0) lows++;
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL held_goal_pulses got %0d expected 1", pulses);
    end
    checks++;
    if (lows != 4) begin
      errors++;
      $display("FAIL held_goal_pause got %0d low cycles expected 4", lows);
    end
    checks++;
    if (ball_enable !== 1'b1 || p_one_score !== 3'd1 || serve_dir !== 1'b1) begin
      errors++;
      $display("FAIL held_goal_final be=%b p1=%0d sd=%b expected 1 1 1", ball_enable, p_one_score, serve_dir);
    end
    goal_right = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_simultaneous();
    int bad = 0;
    wait_play();
    goal_left  = 1'b1;
    goal_right = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (point_pulse !== 1'b0 || ball_enable !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL simultaneous_play bad_cycles=%0d expected 0", bad);
    end
    checks++;
    if (p_one_score !== 3'd1 || p_two_score !== 3'd0) begin
      errors++;
      $display("FAIL simultaneous_scores got %0d/%0d expected 1/0", p_one_score, p_two_score);
    end
    goal_left  = 1'b0;
    goal_right = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_deuce();
    score_point(1'b0);
    score_point(1'b1);
    score_point(1'b0);
    score_point(1'b1);
    score_point(1'b0);
    checks++;
    if (game_over !== 1'b0 || p_one_score !== 3'd3 || p_two_score !== 3'd3) begin
      errors++;
      $display("FAIL deuce_reach got %0d/%0d go=%b expected 3/3 0", p_one_score, p_two_score, game_over);
    end
    score_point(1'b1);
    checks++;
    if (game_over !== 1'b0 || winner !== 2'b00) begin
      errors++;
      $display("FAIL advantage_no_win go=%b win=%b expected 0 00", game_over, winner);
    end
    score_point(1'b1);
    checks++;
    if (game_over !== 1'b1 || winner !== 2'b01 || ball_enable !== 1'b0 || p_one_score !== 3'd5) begin
      errors++;
      $display("FAIL deuce_win go=%b win=%b be=%b p1=%0d expected 1 01 0 5", game_over, winner, ball_enable, p_one_score);
    end
    goal_left = 1'b1;
    tick(); tick(); tick();
    goal_left = 1'b0;
    tick();
    checks++;
    if (game_over !== 1'b1 || p_two_score !== 3'd3 || winner !== 2'b01) begin
      errors++;
      $display("FAIL over_ignores_goal go=%b p2=%0d win=%b expected 1 3 01", game_over, p_two_score, winner);
    end
  endtask

  task automatic test_saturation();
    start_game();
    model_new_game(1'b0);
    checks++;
    if (p_one_score !== 3'd0 || p_two_score !== 3'd0 || winner !== 2'b00 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL restart_clear got %0d/%0d win=%b go=%b expected 0/0 00 0", p_one_score, p_two_score, winner, game_over);
    end
    for (int i = 0; i < 6; i++) begin
      score_point(1'b1);
      score_point(1'b0);
    end
    checks++;
    if (game_over !== 1'b0 || p_one_score !== 3'd6 || p_two_score !== 3'd6) begin
      errors++;
      $display("FAIL six_all got %0d/%0d go=%b expected 6/6 0", p_one_score, p_two_score, game_over);
    end
    score_point(1'b0);
    checks++;
    if (game_over !== 1'b1 || winner !== 2'b10 || p_two_score !== 3'd7) begin
      errors++;
      $display("FAIL saturation_win go=%b win=%b p2=%0d expected 1 10 7", game_over, winner, p_two_score);
    end
    for (int i = 0; i < 2; i++) begin
      goal_right = 1'b1; goal_left = 1'b0;
      tick(); tick();
      goal_right = 1'b0; goal_left = 1'b1;
      tick(); tick();
    end
    goal_left = 1'b0;
    tick();
    checks++;
    if (p_one_score !== 3'd6 || p_two_score !== 3'd7 || winner !== 2'b10) begin
      errors++;
      $display("FAIL saturation_frozen got %0d/%0d win=%b expected 6/7 10", p_one_score, p_two_score, winner);
    end
  endtask

  task automatic test_reset_mid_pause();
    int lows = 0;
    start_game();
    model_new_game(1'b0);
    score_point(1'b1);
    score_point(1'b0);
    score_point(1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_new_game(1'b1);
    checks++;
    if ({p_one_score, p_two_score, ball_enable, serve_dir, point_pulse, game_over, winner} !== 12'b0) begin
      errors++;
      $display("FAIL mid_pause_reset got p1=%0d p2=%0d be=%b sd=%b pp=%b go=%b win=%b expected all zero",
               p_one_score, p_two_score, ball_enable, serve_dir, point_pulse, game_over, winner);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ball_enable === 1'b0) lows++;
    end
    checks++;
    if (lows != 8) begin
      errors++;
      $display("FAIL reset_to_idle low_cycles=%0d expected 8", lows);
    end
  endtask

  task automatic test_start_in_play();
    int bad = 0;
    start_game();
    model_new_game(1'b1);
    score_point(1'b1);
    start = 1'b1;
    wait_play();
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ball_enable !== 1'b1 || p_one_score !== 3'd1 || game_over !== 1'b0) bad++;
    end
    start = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL start_in_play bad_cycles=%0d p1=%0d be=%b expected 0 1 1", bad, p_one_score, ball_enable);
    end
  endtask

  initial begin
    test_reset();
    test_start_pause();
    test_held_goal();
    test_simultaneous();
    test_deuce();
    test_saturation();
    test_reset_mid_pause();
    test_start_in_play();
    tick();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_points outstanding=%0d expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
